// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle. LANES request lanes share one rdata return bus.
interface sram_like_arbiter_if #(
  parameter int LANES  = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [LANES-1:0]          req;
  logic [LANES-1:0]          wr;
  logic [2*LANES-1:0]        size;
  logic [LANES*DATA_W/8-1:0] wstrb;
  logic [LANES*ADDR_W-1:0]   addr;
  logic [LANES*DATA_W-1:0]   wdata;
  logic [LANES-1:0]          addr_ok;
  logic [LANES-1:0]          data_ok;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, wr, size, wstrb, addr, wdata,
                  input  addr_ok, data_ok, rdata);
  modport slave  (input  req, wr, size, wstrb, addr, wdata,
                  output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter with in-order response routing.
//
// state        | meaning
// lock = 0     | grant chosen by arbitration each cycle (gated by fifo full)
// lock = 1     | slave stalled addr_ok; grant pinned on lock_id until handshake
module sram_like_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int RR_MODE     = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  sram_like_arbiter_if.slave               m,
  sram_like_arbiter_if.master              s,
  output logic [$clog2(OUTSTANDING+1)-1:0] outstanding,
  output logic                             err
);
  localparam int IDW   = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = $clog2(OUTSTANDING+1);
  localparam int SW    = DATA_W/8;

  logic             lock;
  logic [IDW-1:0]   lock_id;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   fifo_q [OUTSTANDING];
  logic [PTR_W-1:0] wp, rp;
  logic [CNT_W-1:0] count;

  logic             grant_v;
  logic [IDW-1:0]   g;
  logic [IDW-1:0]   cand;
  logic             full, empty, hs, push, pop, spurious;

  assign full        = (count == CNT_W'(OUTSTANDING));
  assign empty       = (count == '0);
  assign outstanding = count;

  // Grant selection: pinned while locked, otherwise RR or fixed priority.
  always_comb begin
    grant_v = 1'b0;
    g       = '0;
    cand    = '0;
    if (lock) begin
      grant_v = 1'b1;
      g       = lock_id;
    end else if (!full) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (RR_MODE != 0) cand = IDW'((int'(last_grant) + 1 + i) % NUM_CH);
        else              cand = IDW'(i);
        if (!grant_v && m.req[cand]) begin
          grant_v = 1'b1;
          g       = cand;
        end
      end
    end
  end

  // Slave-side request mux and master-side handshake / response routing.
  always_comb begin
    s.req     = '0;
    s.wr      = '0;
    s.size    = '0;
    s.wstrb   = '0;
    s.addr    = '0;
    s.wdata   = '0;
    m.addr_ok = '0;
    m.data_ok = '0;
    m.rdata   = '0;
    pop       = 1'b0;
    spurious  = 1'b0;
    s.req[0]  = resetn & grant_v;
    if (s.req[0]) begin
      s.wr[0] = m.wr[g];
      s.size  = m.size[2*g +: 2];
      s.wstrb = m.wstrb[SW*g +: SW];
      s.addr  = m.addr[ADDR_W*g +: ADDR_W];
      s.wdata = m.wdata[DATA_W*g +: DATA_W];
    end
    hs = s.req[0] & s.addr_ok[0];
    if (hs) m.addr_ok[g] = 1'b1;
    if (resetn && s.data_ok[0]) begin
      if (!empty) begin
        m.data_ok[fifo_q[rp]] = 1'b1;
        m.rdata               = s.rdata;
        pop                   = 1'b1;
      end else if (hs) begin
        m.data_ok[g] = 1'b1;
        m.rdata      = s.rdata;
      end else begin
        spurious = 1'b1;
      end
    end
    // A bypassed response consumes its own handshake, so nothing is queued.
    push = hs & ~(empty & s.data_ok[0]);
  end

  // Lock and round-robin pointer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_id    <= '0;
      last_grant <= IDW'(NUM_CH-1);
    end else begin
      if (hs) begin
        lock       <= 1'b0;
        last_grant <= g;
      end else if (s.req[0]) begin
        lock    <= 1'b1;
        lock_id <= g;
      end
    end
  end

  // Return-order fifo of channel ids.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wp] <= g;
        wp         <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky error on a response with nothing to route it to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       err <= 1'b0;
    else if (spurious) err <= 1'b1;
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: one round-robin DUT plus a fixed-priority DUT sharing stimulus.
module tb_sram_like_arbiter;
  localparam logic [31:0] A0 = 32'h1c00_0000;
  localparam logic [31:0] A1 = 32'h2000_0010;
  localparam logic [31:0] W0 = 32'h1111_0000;
  localparam logic [31:0] W1 = 32'hcafe_f00d;

  logic       clk;
  logic       resetn;
  logic [2:0] outstanding, outstanding_f;
  logic       err, err_f;
  int         checks   = 0;
  int         failures = 0;

  sram_like_arbiter_if #(.LANES(2), .ADDR_W(32), .DATA_W(32)) mi ();
  sram_like_arbiter_if #(.LANES(1), .ADDR_W(32), .DATA_W(32)) si ();
  sram_like_arbiter_if #(.LANES(2), .ADDR_W(32), .DATA_W(32)) mf ();
  sram_like_arbiter_if #(.LANES(1), .ADDR_W(32), .DATA_W(32)) sf ();

  assign mf.req      = mi.req;
  assign mf.wr       = mi.wr;
  assign mf.size     = mi.size;
  assign mf.wstrb    = mi.wstrb;
  assign mf.addr     = mi.addr;
  assign mf.wdata    = mi.wdata;
  assign sf.addr_ok  = si.addr_ok;
  assign sf.data_ok  = si.data_ok;
  assign sf.rdata    = si.rdata;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .RR_MODE(1)) dut (
    .clk(clk), .resetn(resetn), .m(mi), .s(si), .outstanding(outstanding), .err(err));

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .OUTSTANDING(4), .RR_MODE(0)) dut_fp (
    .clk(clk), .resetn(resetn), .m(mf), .s(sf), .outstanding(outstanding_f), .err(err_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic aok, input logic dok, input logic [31:0] rd);
    mi.req        = req;
    si.addr_ok[0] = aok;
    si.data_ok[0] = dok;
    si.rdata      = rd;
    #1;
  endtask

  task automatic reset_pulse();
    resetn = 1'b0;
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    cyc();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    // 1. reset with random inputs
    for (int i = 0; i < 3; i++) begin
      mi.req = 2'($urandom); mi.wr = 2'($urandom); mi.size = 4'($urandom);
      mi.wstrb = 8'($urandom); mi.addr = {$urandom, $urandom};
      mi.wdata = {$urandom, $urandom};
      drive(2'($urandom | 1), 1'($urandom), 1'b1, $urandom);
      check("rst_s_req",   64'(si.req),     64'd0);
      check("rst_s_addr",  64'(si.addr),    64'd0);
      check("rst_s_wdata", 64'(si.wdata),   64'd0);
      check("rst_addr_ok", 64'(mi.addr_ok), 64'd0);
      check("rst_data_ok", 64'(mi.data_ok), 64'd0);
      check("rst_rdata",   64'(mi.rdata),   64'd0);
      check("rst_outst",   64'(outstanding), 64'd0);
      check("rst_err",     64'(err),        64'd0);
      cyc();
    end
    mi.wr = 2'b10; mi.size = {2'd2, 2'd0}; mi.wstrb = {4'hf, 4'h1};
    mi.addr = {A1, A0}; mi.wdata = {W1, W0};
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    resetn = 1'b1;
    cyc();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("first_grant_aok",  64'(mi.addr_ok), 64'h1);
    check("first_grant_addr", 64'(si.addr),    64'(A0));
    cyc();
    drive(2'b00, 1'b0, 1'b1, 32'h5555_aaaa);
    check("first_outst", 64'(outstanding), 64'd1);
    check("first_dok",   64'(mi.data_ok),  64'h1);
    cyc();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("first_outst0", 64'(outstanding), 64'd0);

    // 2. single read on channel 0
    cyc(); drive(2'b01, 1'b0, 1'b0, 32'h0);
    check("rd_c0_sreq",  64'(si.req),     64'd1);
    check("rd_c0_saddr", 64'(si.addr),    64'(A0));
    check("rd_c0_swr",   64'(si.wr),      64'd0);
    check("rd_c0_aok",   64'(mi.addr_ok), 64'd0);
    cyc(); drive(2'b01, 1'b0, 1'b0, 32'h0);
    check("rd_c1_outst", 64'(outstanding), 64'd0);
    cyc(); drive(2'b01, 1'b1, 1'b0, 32'h0);
    check("rd_c2_aok",   64'(mi.addr_ok), 64'h1);
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("rd_c3_outst", 64'(outstanding), 64'd1);
    check("rd_c3_sreq",  64'(si.req),      64'd0);
    cyc(); drive(2'b00, 1'b0, 1'b1, 32'hdead_beef);
    check("rd_c4_dok",   64'(mi.data_ok), 64'h1);
    check("rd_c4_rdata", 64'(mi.rdata),   64'hdead_beef);
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("rd_c5_outst", 64'(outstanding), 64'd0);
    check("rd_c5_dok",   64'(mi.data_ok),  64'd0);

    // 3 + 5. continuous requests, RR vs fixed, then fill and drain
    reset_pulse();
    begin
      logic [1:0] rr_exp [4];
      rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
        cyc(); drive(2'b11, 1'b1, 1'b0, 32'h0);
        check($sformatf("rr_grant%0d", i), 64'(mi.addr_ok), 64'(rr_exp[i]));
        if (i < 3) check($sformatf("fp_grant%0d", i), 64'(mf.addr_ok), 64'h1);
        if (i == 3) check("fp_outst3", 64'(outstanding_f), 64'd3);
      end
    end
    cyc(); drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("full_sreq",  64'(si.req),      64'd0);
    check("full_outst", 64'(outstanding), 64'd4);
    cyc(); drive(2'b11, 1'b1, 1'b1, 32'h0000_0001);
    check("full_pop_dok",  64'(mi.data_ok), 64'h1);
    check("full_pop_sreq", 64'(si.req),     64'd0);
    cyc(); drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("resume_sreq", 64'(si.req),      64'd1);
    check("resume_aok",  64'(mi.addr_ok),  64'h1);
    check("resume_outst", 64'(outstanding), 64'd3);
    begin
      logic [1:0] ord [4];
      ord = '{2'b10, 2'b01, 2'b10, 2'b01};
      for (int i = 0; i < 4; i++) begin
        cyc(); drive(2'b00, 1'b0, 1'b1, 32'h100 + 32'(i));
        check($sformatf("order%0d", i), 64'(mi.data_ok), 64'(ord[i]));
        check($sformatf("order_rd%0d", i), 64'(mi.rdata), 64'h100 + 64'(i));
      end
    end
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("drain_outst", 64'(outstanding), 64'd0);
    check("drain_err",   64'(err),         64'd0);
    check("fp_err",      64'(err_f),       64'd0);

    // 4. lock holds channel 1 against channel 0
    reset_pulse();
    cyc(); drive(2'b10, 1'b0, 1'b0, 32'h0);
    check("lk_c0_saddr", 64'(si.addr), 64'(A1));
    for (int i = 1; i < 3; i++) begin
      cyc(); drive(2'b11, 1'b0, 1'b0, 32'h0);
      check($sformatf("lk_c%0d_saddr", i), 64'(si.addr),    64'(A1));
      check($sformatf("lk_c%0d_aok", i),   64'(mi.addr_ok), 64'd0);
    end
    cyc(); drive(2'b11, 1'b1, 1'b0, 32'h0);
    check("lk_hs_aok",   64'(mi.addr_ok), 64'h2);
    check("lk_hs_saddr", 64'(si.addr),    64'(A1));
    check("lk_hs_swr",   64'(si.wr),      64'd1);
    check("lk_hs_size",  64'(si.size),    64'd2);
    check("lk_hs_wstrb", 64'(si.wstrb),   64'hf);
    check("lk_hs_wdata", 64'(si.wdata),   64'(W1));
    cyc(); drive(2'b01, 1'b1, 1'b0, 32'h0);
    check("lk_next_aok",   64'(mi.addr_ok), 64'h1);
    check("lk_next_saddr", 64'(si.addr),    64'(A0));
    check("lk_next_wstrb", 64'(si.wstrb),   64'h1);
    check("lk_next_wdata", 64'(si.wdata),   64'(W0));
    cyc(); drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("lk_rsp0", 64'(mi.data_ok), 64'h2);
    cyc(); drive(2'b00, 1'b0, 1'b1, 32'h0);
    check("lk_rsp1", 64'(mi.data_ok), 64'h1);
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("lk_outst", 64'(outstanding), 64'd0);

    // 6. bypass on empty fifo, then spurious response
    cyc(); drive(2'b10, 1'b1, 1'b1, 32'h1234_5678);
    check("byp_aok",   64'(mi.addr_ok), 64'h2);
    check("byp_dok",   64'(mi.data_ok), 64'h2);
    check("byp_rdata", 64'(mi.rdata),   64'h1234_5678);
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("byp_outst", 64'(outstanding), 64'd0);
    check("byp_err",   64'(err),         64'd0);
    cyc(); drive(2'b00, 1'b0, 1'b1, 32'h9999_9999);
    check("spur_dok",  64'(mi.data_ok), 64'd0);
    cyc(); drive(2'b00, 1'b0, 1'b0, 32'h0);
    check("spur_err",  64'(err), 64'd1);
    check("spur_outst", 64'(outstanding), 64'd0);
    cyc(); cyc();
    check("spur_err_sticky", 64'(err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
